// File: rtl/latch_writer.sv
// latch_writer: drives a shared data bus and one gate per downstream transparent
// latch. Each write is a setup / gate-open / hold sequence with programmable
// cycle counts. Every output comes straight from a flop so the gates cannot glitch.
module latch_writer #(
    parameter int DATA_W    = 8,
    parameter int NUM_LATCH = 4,
    parameter int AW        = 3,
    parameter int SETUP_CYC = 1,
    parameter int GATE_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AW-1:0]        req_addr_i,
    input  logic [DATA_W-1:0]    req_data_i,
    output logic [DATA_W-1:0]    d_o,
    output logic [NUM_LATCH-1:0] gate_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    // Stop elaboration on timing or latch-count settings the sequencer cannot honour.
    if (SETUP_CYC < 1 || GATE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_cycles
        $error("latch_writer: SETUP_CYC, GATE_CYC and HOLD_CYC must all be >= 1");
    end
    if (NUM_LATCH > (1 << AW)) begin : g_bad_latch_count
        $error("latch_writer: NUM_LATCH does not fit in AW address bits");
    end

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] GATE  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    // One shared phase counter. It counts 0 .. len-1 inside a phase and restarts
    // at each phase change, so it never needs to hold more than MAX_CYC-1.
    localparam int MAX_SG  = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
    localparam int MAX_CYC = (MAX_SG > HOLD_CYC) ? MAX_SG : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] GATE_LAST  = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    // One bit wider than the address, so that NUM_LATCH == 2**AW still compares correctly.
    localparam logic [AW:0] ADDR_LIMIT = (AW + 1)'(NUM_LATCH);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q;
    logic             accept_ok, accept_bad, done_d;
    logic             addr_in_range;

    assign addr_in_range = ({1'b0, req_addr_i} < ADDR_LIMIT);

    // Next-state and phase-counter logic for the setup / gate / hold sequence.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept_ok  = 1'b0;
        accept_bad = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (addr_in_range) begin
                        accept_ok = 1'b1;
                        state_d   = SETUP;
                        cnt_d     = '0;
                    end else begin
                        accept_bad = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = GATE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GATE: begin
                if (cnt_q == GATE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, captured request and every output are registered. The outputs are
    // computed from the next state, so they line up with the state they describe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            d_o         <= '0;
            gate_o      <= '0;
            busy_o      <= 1'b0;
            req_ready_o <= 1'b1;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every flop samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept_ok) begin
                addr_q <= req_addr_i;
                d_o    <= req_data_i;
            end
            // The address was captured at least one SETUP cycle earlier, so addr_q is stable here.
            gate_o      <= (state_d == GATE) ? (NUM_LATCH'(1) << addr_q) : '0;
            busy_o      <= (state_d != IDLE);
            req_ready_o <= (state_d == IDLE);
            done_o      <= done_d;
            err_o       <= accept_bad;
        end
    end

endmodule

// File: tb/tb_latch_writer.sv
// tb_latch_writer: two latch_writer instances (default timing and 3/1/2 timing)
// share one stimulus stream. Each instance is compared every cycle against a
// transaction-level model that tracks elapsed cycles since accept.
module tb_latch_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid;
    logic [2:0] req_addr;
    logic [7:0] req_data;

    logic       a_ready, a_busy, a_done, a_err;
    logic [7:0] a_d;
    logic [3:0] a_gate;
    logic       b_ready, b_busy, b_done, b_err;
    logic [7:0] b_d;
    logic [3:0] b_gate;

    latch_writer u_a (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(a_ready),
        .req_addr_i(req_addr), .req_data_i(req_data), .d_o(a_d), .gate_o(a_gate),
        .busy_o(a_busy), .done_o(a_done), .err_o(a_err)
    );

    latch_writer #(.SETUP_CYC(3), .GATE_CYC(1), .HOLD_CYC(2)) u_b (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(b_ready),
        .req_addr_i(req_addr), .req_data_i(req_data), .d_o(b_d), .gate_o(b_gate),
        .busy_o(b_busy), .done_o(b_done), .err_o(b_err)
    );

    // t = cycles since accept (0 means idle); a/d = captured address and data.
    typedef struct {
        int         t;
        int         a;
        logic [7:0] d;
        bit         done;
        bit         err;
    } model_t;

    model_t ma, mb;
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic model_t model_reset();
        model_t m;
        m.t = 0; m.a = 0; m.d = 8'h00; m.done = 1'b0; m.err = 1'b0;
        return m;
    endfunction

    // One clock edge: a transaction lasts s+g+h cycles and then done follows.
    function automatic model_t model_step(model_t m, int s, int g, int h);
        model_t n = m;
        n.done = 1'b0;
        n.err  = 1'b0;
        if (m.t > 0) begin
            if (m.t == s + g + h) begin
                n.t    = 0;
                n.done = 1'b1;
            end else begin
                n.t = m.t + 1;
            end
        end else if (req_valid) begin
            if (int'(req_addr) < 4) begin
                n.t = 1;
                n.a = int'(req_addr);
                n.d = req_data;
            end else begin
                n.err = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic check_dut(input string n, input model_t m, input int s, input int g,
                             input logic [7:0] d, input logic [3:0] gate, input logic busy,
                             input logic ready, input logic done, input logic err);
        logic [3:0] exp_gate;
        exp_gate = (m.t > s && m.t <= s + g) ? 4'(1 << m.a) : 4'b0000;
        check({n, ".d"},     32'(d),     32'(m.d));
        check({n, ".gate"},  32'(gate),  32'(exp_gate));
        check({n, ".busy"},  32'(busy),  32'(m.t != 0));
        check({n, ".ready"}, 32'(ready), 32'(m.t == 0));
        check({n, ".done"},  32'(done),  32'(m.done));
        check({n, ".err"},   32'(err),   32'(m.err));
    endtask

    task automatic check_both();
        check_dut("a", ma, 1, 2, a_d, a_gate, a_busy, a_ready, a_done, a_err);
        check_dut("b", mb, 3, 1, b_d, b_gate, b_busy, b_ready, b_done, b_err);
    endtask

    // Advance one clock: models step on the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        ma = model_step(ma, 1, 2, 1);
        mb = model_step(mb, 3, 1, 2);
        @(negedge clk);
        check_both();
    endtask

    // Assert reset between edges and confirm the outputs clear without any clock edge.
    task automatic mid_cycle_reset();
        #2 rst = 1'b1;
        #1;
        ma = model_reset();
        mb = model_reset();
        check("rst.a_gate", 32'(a_gate), 32'h0);
        check("rst.a_d",    32'(a_d),    32'h0);
        check("rst.b_gate", 32'(b_gate), 32'h0);
        check("rst.b_d",    32'(b_d),    32'h0);
        check_both();
        #1 rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 3'd0;
        req_data  = 8'h00;
        ma = model_reset();
        mb = model_reset();
        #1;
        check_both();
        @(negedge clk);
        rst = 1'b0;

        // Write 0xA5 to latch 2, then keep a second request (latch 1, 0x3C) pending.
        req_valid = 1'b1;
        req_addr  = 3'd2;
        req_data  = 8'hA5;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            tick();
            check("a.gate_tl",  32'(a_gate),
                  (cyc == 2 || cyc == 3) ? 32'h4 : (cyc == 7 || cyc == 8) ? 32'h2 : 32'h0);
            check("a.done_tl",  32'(a_done),  32'(cyc == 5 || cyc == 10));
            check("a.ready_tl", 32'(a_ready), 32'(cyc == 5 || cyc >= 10));
            check("a.d_tl",     32'(a_d),     (cyc <= 5) ? 32'hA5 : 32'h3C);
            if (cyc == 1) begin
                check("b.gate_tl", 32'(b_gate), 32'h0);
                req_addr = 3'd1;
                req_data = 8'h3C;
            end
            if (cyc == 4) check("b.gate_tl", 32'(b_gate), 32'h4);
            if (cyc == 5) check("b.gate_tl", 32'(b_gate), 32'h0);
            if (cyc == 6) begin
                check("b.done_tl", 32'(b_done), 32'h0);
                req_valid = 1'b0;
            end
            if (cyc == 7) check("b.done_tl", 32'(b_done), 32'h1);
            // Scramble the request inputs while the second transaction runs.
            if (cyc >= 6) begin
                req_data = 8'($urandom);
                req_addr = 3'($urandom);
            end
        end

        // Out-of-range address: err pulse for one cycle, nothing else changes.
        req_valid = 1'b1;
        req_addr  = 3'd5;
        req_data  = 8'hFF;
        tick();
        check("a.err_oor", 32'(a_err), 32'h1);
        check("a.d_oor",   32'(a_d),   32'h3C);
        req_valid = 1'b0;
        tick();
        check("a.err_oor_clr", 32'(a_err), 32'h0);
        repeat (3) tick();

        // Reset in the middle of GATE (latch 0, data 0x77): abandoned, no done.
        req_valid = 1'b1;
        req_addr  = 3'd0;
        req_data  = 8'h77;
        tick();
        req_valid = 1'b0;
        tick();
        check("a.gate_pre_rst", 32'(a_gate), 32'h1);
        mid_cycle_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("a.done_post_rst", 32'(a_done), 32'h0);
        end

        // Random traffic with occasional mid-cycle resets.
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = 3'($urandom_range(0, 7));
            req_data  = 8'($urandom);
            if ($urandom_range(0, 59) == 0) mid_cycle_reset();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
